// File: rtl/lane_accumulator.sv
// lane_accumulator: reduces eight unsigned lanes per beat through a 3-stage registered
// adder tree. It then accumulates the beat sums over a frame, which is a maximal run of
// consecutive valid beats, and reports the frame total when the frame closes.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    marks in0..in7 as a valid beat
//   in0..in7    lane data (IN_W bits, unsigned)
//   sum         total of the last completed frame (holds until the next frame closes)
//   sum_valid   one-cycle pulse when sum/beat_count update
//   beat_count  beats in the last completed frame, saturating at all-ones
//   busy        a frame is somewhere in the pipeline or the accumulator
module lane_accumulator #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned SUM_W = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in0,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [IN_W-1:0]  in3,
    input  logic [IN_W-1:0]  in4,
    input  logic [IN_W-1:0]  in5,
    input  logic [IN_W-1:0]  in6,
    input  logic [IN_W-1:0]  in7,
    output logic [SUM_W-1:0] sum,
    output logic             sum_valid,
    output logic [CNT_W-1:0] beat_count,
    output logic             busy
);

    typedef enum logic {StIdle, StAcc} state_t;

    // Adder tree. Each stage is one bit wider than the last, so nothing truncates.
    logic [IN_W:0]   p0_q, p1_q, p2_q, p3_q;
    logic [IN_W+1:0] s0_q, s1_q;
    logic [IN_W+2:0] b3_q;
    logic            v1_q, v2_q, v3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            s0_q <= '0;
            s1_q <= '0;
            b3_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            p0_q <= (IN_W+1)'(in0) + (IN_W+1)'(in1);
            p1_q <= (IN_W+1)'(in2) + (IN_W+1)'(in3);
            p2_q <= (IN_W+1)'(in4) + (IN_W+1)'(in5);
            p3_q <= (IN_W+1)'(in6) + (IN_W+1)'(in7);
            s0_q <= (IN_W+2)'(p0_q) + (IN_W+2)'(p1_q);
            s1_q <= (IN_W+2)'(p2_q) + (IN_W+2)'(p3_q);
            b3_q <= (IN_W+3)'(s0_q) + (IN_W+3)'(s1_q);
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Frame accumulator.
    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] beat_count_q, beat_count_d;
    logic             sum_valid_d;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        beat_count_d = beat_count_q;
        sum_valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (v3_q) begin
                    // The first beat overwrites, so no stale total from the previous
                    // frame carries over.
                    acc_d   = SUM_W'(b3_q);
                    cnt_d   = CNT_W'(1);
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (v3_q) begin
                    acc_d = acc_q + SUM_W'(b3_q);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    sum_d        = acc_q;
                    beat_count_d = cnt_q;
                    sum_valid_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            beat_count_q <= '0;
            sum_valid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            beat_count_q <= beat_count_d;
            sum_valid    <= sum_valid_d;
        end
    end

    assign sum        = sum_q;
    assign beat_count = beat_count_q;
    assign busy       = v1_q | v2_q | v3_q | (state_q == StAcc);

endmodule

// File: tb/tb_lane_accumulator.sv
// Testbench for lane_accumulator. The stimulus tasks compute each frame's expected total
// and beat count, and the cycle its pulse is due, with plain arithmetic. They queue the
// result when the frame ends. A separate monitor pops the queue on every sum_valid pulse.
module tb_lane_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] ln = '0;
    logic [31:0] sum;
    logic        sum_valid;
    logic [5:0]  beat_count;
    logic        busy;

    lane_accumulator #(.IN_W(8), .SUM_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in0        (ln[7:0]),
        .in1        (ln[15:8]),
        .in2        (ln[23:16]),
        .in3        (ln[31:24]),
        .in4        (ln[39:32]),
        .in5        (ln[47:40]),
        .in6        (ln[55:48]),
        .in7        (ln[63:56]),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .beat_count (beat_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint s;
        int     c;
        int     t;
    } exp_t;
    exp_t q[$];

    int     tests = 0;
    int     fails = 0;
    longint fsum = 0;
    int     fcnt = 0;
    int     last_cyc = 0;
    bit     in_frame = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lane_total(input logic [63:0] l);
        int t = 0;
        for (int i = 0; i < 8; i++) t += int'(l[8*i +: 8]);
        return t;
    endfunction

    function automatic logic [63:0] splat(input int v);
        logic [63:0] l;
        for (int i = 0; i < 8; i++) l[8*i +: 8] = 8'(v);
        return l;
    endfunction

    // One valid beat. The beat is sampled on the next rising edge.
    task automatic beat(input logic [63:0] l);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        ln       = l;
        fsum     = (fsum + longint'(lane_total(l))) % (64'd1 << 32);
        fcnt     = (fcnt == 63) ? 63 : fcnt + 1;
        last_cyc = cyc;
        in_frame = 1'b1;
    endtask

    // Idle cycles with garbage lanes. The first one closes any open frame. Its pulse is
    // due 4 edges after the edge that samples the last beat.
    task automatic idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            ln       = {$urandom, $urandom};
            if (in_frame) begin
                e.s = fsum;
                e.c = fcnt;
                e.t = last_cyc + 5;
                q.push_back(e);
            end
            in_frame = 1'b0;
            fsum     = 0;
            fcnt     = 0;
        end
    endtask

    // Monitor: every pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst && sum_valid) begin
            if (q.size() == 0) begin
                check("unexpected_sum_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", longint'(sum), e.s);
                check("beat_count", longint'(beat_count), longint'(e.c));
                check("pulse_cycle", longint'(cyc), longint'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nlen;
        // Asynchronous reset, then release it mid-cycle.
        #2 rst = 1'b0;
        #1;
        check("rst_sum", longint'(sum), 0);
        check("rst_sum_valid", longint'(sum_valid), 0);
        check("rst_beat_count", longint'(beat_count), 0);
        check("rst_busy", longint'(busy), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        idle(4);
        check("idle_busy", longint'(busy), 0);

        // 32 beats of all ones.
        for (int k = 0; k < 32; k++) beat(splat(1));
        #2 check("busy_in_frame", longint'(busy), 1);
        idle(6);
        check("busy_after_frame", longint'(busy), 0);
        check("sum_hold_256", longint'(sum), 256);

        // 32 beats of all 255s.
        for (int k = 0; k < 32; k++) beat(splat(255));
        idle(8);
        check("sum_hold_65280", longint'(sum), 65280);

        // A ramp on in0 only, then on in7 only.
        for (int k = 0; k < 32; k++) beat({56'd0, 8'(k)});
        idle(8);
        check("ramp_in0", longint'(sum), 496);
        for (int k = 0; k < 32; k++) beat({8'(k), 56'd0});
        idle(8);
        check("ramp_in7", longint'(sum), 496);

        // A single beat, then a one-cycle gap, then 3 beats of all 2s.
        beat({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        idle(1);
        for (int k = 0; k < 3; k++) beat(splat(2));
        idle(8);
        check("gap_second_sum", longint'(sum), 48);
        check("gap_second_cnt", longint'(beat_count), 3);
        check("gap_queue_drained", longint'(q.size()), 0);

        // Reset asserted mid-frame discards the partial frame.
        for (int k = 0; k < 10; k++) beat(splat(10));
        #3 rst = 1'b0;
        in_valid = 1'b0;
        in_frame = 1'b0;
        fsum     = 0;
        fcnt     = 0;
        q.delete();
        #1;
        check("midrst_sum", longint'(sum), 0);
        check("midrst_cnt", longint'(beat_count), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_sum_valid", longint'(sum_valid), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        idle(8);
        check("postrst_sum", longint'(sum), 0);
        check("postrst_busy", longint'(busy), 0);
        for (int k = 0; k < 4; k++) beat(splat(10));
        idle(8);
        check("postrst_frame", longint'(sum), 320);

        // 70 beats: beat_count saturates at 63.
        for (int k = 0; k < 70; k++) beat(splat(1));
        idle(8);
        check("sat_sum", longint'(sum), 560);
        check("sat_cnt", longint'(beat_count), 63);

        // Random frames with random gaps of 1 to 3 cycles.
        for (int f = 0; f < 40; f++) begin
            nlen = $urandom_range(1, 70);
            for (int k = 0; k < nlen; k++) beat({$urandom, $urandom});
            idle($urandom_range(1, 3));
        end

        // Drain, bounded.
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        idle(2);
        check("final_queue_drained", longint'(q.size()), 0);
        check("final_busy", longint'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_accumulator.md
Name: lane_accumulator

Overview:
- Downstream consumer of the 8-lane byte selector.
- Accepts eight 8-bit lanes per beat, qualified by in_valid, and reduces each beat through a 3-stage pipelined adder tree.
- Accumulates the beat sums over a contiguous run of valid beats (a frame) and presents the frame total on sum for the normalizer.
- Also provides a one-cycle completion pulse and the frame's beat count.

Parameters:
- IN_W, 8: width of each input lane (unsigned).
- SUM_W, 32: width of the accumulator and of sum.
- CNT_W, 6: width of beat_count. The counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets the block immediately, independent of clk.
- in_valid  input  1  high marks the current lanes as a valid beat.
- in0..in7  input  IN_W each  lane data, sampled together with in_valid.
- sum  output  SUM_W  total of the last completed frame.
- sum_valid  output  1  one-cycle pulse when sum updates.
- beat_count  output  CNT_W  number of beats in the last completed frame.
- busy  output  1  high while a frame is in flight anywhere in the pipeline or accumulator.

Behaviour:
- Reset (rst=0, async):
  - all pipeline registers, valid bits, accumulator and counters clear to 0.
  - Outputs reset to sum=0, sum_valid=0, beat_count=0, busy=0.
  - A partial frame in progress is discarded. No sum_valid is produced for it.
- Stage 1, registered: four pair sums (in0+in1, in2+in3, in4+in5, in6+in7), each IN_W+1 bits. v1<=in_valid.
- Stage 2, registered: two sums of IN_W+2 bits. v2<=v1.
- Stage 3, registered: beat sum b3 of IN_W+3 bits. v3<=v2.
- All additions are unsigned and zero-extended. There is no truncation inside the tree.
- Accumulator states: IDLE and ACC.
  - IDLE with v3=1: acc<=b3 (this overwrites, it does not add), cnt<=1, go to ACC.
  - ACC with v3=1: acc<=acc+b3, cnt<=cnt+1 (saturating at all-ones).
  - ACC with v3=0: frame closes. sum<=acc, beat_count<=cnt, sum_valid<=1 for exactly one cycle, go to IDLE.
- acc is SUM_W bits and wraps modulo 2^SUM_W. No overflow flag is provided.
- Latency: sum_valid is high in the cycle following the 4th rising edge after the edge that sampled the last valid beat.
  - Edge E0 samples the last beat, E1 is stage 2, E2 is stage 3, E3 makes the accumulator final.
  - At E4 v3=0, so sum and sum_valid register.
- Frame boundaries:
  - A frame is any maximal run of consecutive in_valid=1 cycles. The first in_valid=0 cycle terminates it.
  - A single-beat frame is legal.
  - With a one-cycle gap between frames, frame N closes in the same edge window as the gap. Frame N+1 starts clean via the IDLE overwrite, and no beat from N+1 leaks into N.
  - There is no back-pressure. The block accepts one beat every cycle.
- sum and beat_count hold their values until the next frame closes. They do not clear at frame start. sum_valid is 0 in every other cycle.
- in_valid=0 cycles carry don't-care lane data, which never affects acc.
- busy = v1|v2|v3|(state==ACC). After reset with in_valid=0, busy stays 0.
- Downstream rounding (sum+128, bits [15:8]) belongs to the normalizer, not to this block.

Test Plan:
- Reset release, then 32 beats with all lanes=1, then in_valid=0 → sum=256, beat_count=32, sum_valid a single pulse exactly 4 edges after the last beat, busy low the following cycle.
- 32 beats with all lanes=255 → sum=65280 (0x0000FF00), beat_count=32. The normalizer sees led=0xFF.
- 32 beats with in0=k (k=0..31) and other lanes 0 → sum=496. Repeat with the ramp on in7 only → sum=496, which checks every lane feeds the tree.
- Single beat with lanes 1..8 → sum=36, beat_count=1. Then 3 beats of all 2s separated from it by a one-cycle gap → sum=48, beat_count=3, two distinct sum_valid pulses.
- Frame of 20 beats with lanes=10, rst pulled low asynchronously (mid-cycle) at beat 10 and released → sum=0, beat_count=0, busy=0, no sum_valid. A subsequent 4-beat frame with lanes=10 → sum=320.
- 70-beat frame with all lanes=1 → sum=560, beat_count=63 (saturated).
